// File: rtl/trap_unit_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses, cause codes,
// status bit positions and FSM state encoding.
package trap_unit_pkg;

  // CSR addresses
  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMip      = 12'h344;

  // mcause values
  localparam logic [31:0] CauseIllegal    = 32'd2;
  localparam logic [31:0] CauseBreakpoint = 32'd3;
  localparam logic [31:0] CauseEcallM     = 32'd11;
  localparam logic [31:0] CauseMei        = 32'h8000_000B;

  // Implemented bit positions
  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned MieMeie     = 11;
  localparam int unsigned MipMeip     = 11;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StEnter  = 2'b01,
    StReturn = 2'b10
  } trap_state_e;

  // Word-aligned view of a PC-like CSR value.
  function automatic logic [31:0] csr_align(input logic [31:0] val);
    return {val[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_unit_irq_sync.sv
// Multi-flop synchroniser for the asynchronous external interrupt line.
module trap_unit_irq_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SyncStages-1:0] sync_q;

  // Shift chain; stage 0 may go metastable, later stages resolve it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
    end
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap and CSR unit: owns the M-mode CSRs, kills trapping
// instructions and drives a registered one-cycle PC redirect to mtvec or mepc.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0010,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic        I_instvalid,
  input  logic [31:0] I_pc,
  input  logic [31:0] I_instr,
  input  logic        I_ecall,
  input  logic        I_ebreak,
  input  logic        I_illegalinst,
  input  logic        I_mret,
  input  logic        I_msrwen,
  input  logic [11:0] I_csraddr,
  input  logic [31:0] I_csrwdata,
  input  logic        I_irq,
  output logic [31:0] O_csrrdata,
  output logic        O_kill,
  output logic        O_redirect,
  output logic [31:0] O_redirectpc
);

  trap_state_e state_q, state_d;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q, mie_meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic        irq_s;
  logic        irq_pend;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;

  trap_unit_irq_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (I_clk),
    .rst_ni(I_rstn),
    .d_i   (I_irq),
    .q_o   (irq_s)
  );

  assign irq_pend = irq_s & mstatus_mie_q & mie_meie_q;

  // Prioritised trap selection: interrupt > illegal > ebreak > ecall.
  always_comb begin
    trap_req   = 1'b1;
    trap_cause = '0;
    trap_tval  = '0;
    if (irq_pend) begin
      trap_cause = CauseMei;
    end else if (I_illegalinst) begin
      trap_cause = CauseIllegal;
      trap_tval  = I_instr;
    end else if (I_ebreak) begin
      trap_cause = CauseBreakpoint;
      trap_tval  = I_pc;
    end else if (I_ecall) begin
      trap_cause = CauseEcallM;
    end else begin
      trap_req = 1'b0;
    end
  end

  // Combinational CSR read; returns the pre-write value during a CSRRW.
  always_comb begin
    O_csrrdata = '0;
    case (I_csraddr)
      CsrMstatus: begin
        O_csrrdata[MstatusMie]  = mstatus_mie_q;
        O_csrrdata[MstatusMpie] = mstatus_mpie_q;
      end
      CsrMie:      O_csrrdata[MieMeie] = mie_meie_q;
      CsrMtvec:    O_csrrdata = csr_align(mtvec_q);
      CsrMscratch: O_csrrdata = mscratch_q;
      CsrMepc:     O_csrrdata = csr_align(mepc_q);
      CsrMcause:   O_csrrdata = mcause_q;
      CsrMtval:    O_csrrdata = mtval_q;
      CsrMip:      O_csrrdata[MipMeip] = irq_s;
      default:     O_csrrdata = '0;
    endcase
  end

  // FSM next state, CSR updates and kill/redirect outputs.
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    O_kill         = 1'b0;
    O_redirect     = 1'b0;
    O_redirectpc   = '0;

    unique case (state_q)
      StRun: begin
        if (I_instvalid) begin
          if (trap_req) begin
            // Trapping instruction never commits, including its CSR write.
            O_kill         = 1'b1;
            mepc_d         = csr_align(I_pc);
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            state_d        = StEnter;
          end else if (I_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            state_d        = StReturn;
          end else if (I_msrwen) begin
            case (I_csraddr)
              CsrMstatus: begin
                mstatus_mie_d  = I_csrwdata[MstatusMie];
                mstatus_mpie_d = I_csrwdata[MstatusMpie];
              end
              CsrMie:      mie_meie_d = I_csrwdata[MieMeie];
              CsrMtvec:    mtvec_d    = csr_align(I_csrwdata);
              CsrMscratch: mscratch_d = I_csrwdata;
              CsrMepc:     mepc_d     = csr_align(I_csrwdata);
              CsrMcause:   mcause_d   = I_csrwdata;
              CsrMtval:    mtval_d    = I_csrwdata;
              default:     ;
            endcase
          end
        end
      end
      StEnter: begin
        // Squash the wrong-path instruction fetched behind the trap.
        O_kill       = 1'b1;
        O_redirect   = 1'b1;
        O_redirectpc = csr_align(mtvec_q);
        state_d      = StRun;
      end
      StReturn: begin
        O_kill       = 1'b1;
        O_redirect   = 1'b1;
        O_redirectpc = csr_align(mepc_q);
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // State and CSR registers.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q        <= StRun;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= csr_align(RESET_MTVEC);
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

endmodule
